// File: rtl/voice_pwm_dac.sv
// voice_pwm_dac
// Single-bit PWM output stage for the 5-voice synthesizer. Once per frame it
// latches the voice-mix count, clamped to LEVELS, and holds pwm_out high for
// sample*SLOT_CYCLES clocks from the start of the frame. One frame is
// LEVELS*SLOT_CYCLES clocks long.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       run request; level-sensitive, only acted on at frame boundaries
//   sum_in[3:0]  unsigned voice-mix count; LEVELS and above is full scale
//   pwm_out      registered PWM output
//   frame_start  registered one-cycle pulse at frame position 0
//   clip         registered; high for a frame whose latched sum_in exceeded LEVELS
module voice_pwm_dac #(
    parameter int LEVELS      = 5,
    parameter int SLOT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] sum_in,
    output logic       pwm_out,
    output logic       frame_start,
    output logic       clip
);

    localparam int LW = $clog2(LEVELS + 1);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] sample_q, sample_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          pwm_d, fs_d, clip_d;

    logic          over;
    logic [LW-1:0] clamp;
    logic          last_slot, wrap, load;

    // Clamp decision uses the full 4-bit input so values above LEVELS that
    // would alias after truncation still saturate.
    assign over      = int'(sum_in) > LEVELS;
    assign clamp     = over ? LW'(LEVELS) : LW'(sum_in);
    assign last_slot = (slot_q == SW'(SLOT_CYCLES - 1));
    assign wrap      = last_slot && (level_q == LW'(LEVELS - 1));

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        slot_d   = slot_q;
        sample_d = sample_q;
        pwm_d    = pwm_out;
        fs_d     = 1'b0;
        clip_d   = clip;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    load = 1'b1;
                end else begin
                    level_d = '0;
                    slot_d  = '0;
                    pwm_d   = 1'b0;
                    clip_d  = 1'b0;
                end
            end
            RUN: begin
                if (wrap) begin
                    // enable is only consulted here, so a drop mid-frame
                    // never shortens the frame in progress.
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        level_d = '0;
                        slot_d  = '0;
                        pwm_d   = 1'b0;
                        clip_d  = 1'b0;
                    end
                end else begin
                    slot_d  = last_slot ? '0 : slot_q + 1'b1;
                    level_d = last_slot ? level_q + 1'b1 : level_q;
                    pwm_d   = (level_d < sample_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame load: the new sample drives pwm_out from position 0, so a
        // full-scale sample stays high straight across the wrap.
        if (load) begin
            state_d  = RUN;
            sample_d = clamp;
            clip_d   = over;
            level_d  = '0;
            slot_d   = '0;
            fs_d     = 1'b1;
            pwm_d    = (clamp != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            slot_q      <= '0;
            sample_q    <= '0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            clip        <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            slot_q      <= slot_d;
            sample_q    <= sample_d;
            pwm_out     <= pwm_d;
            frame_start <= fs_d;
            clip        <= clip_d;
        end
    end

endmodule
